// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the low-power cache and its refill controller:
//   line geometry, refill FSM state encoding and a line-address helper.
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_WORD,
    RESP
  } refill_state_t;

  // Byte address of the first word of the line containing addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

endpackage

// File: rtl/mem_refill_controller.sv
// -----------------------------------------------------------------------------
// mem_refill_controller
//   Serves the cache miss / write-through port. A read becomes a 4-beat burst
//   of word reads assembled into a 128-bit line; a write becomes one word
//   write-through. Each beat is guarded by a wait-cycle timeout.
//
// Ports
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   mem_req         cache request, sampled only while idle
//   mem_write       1 = word write-through, 0 = line refill
//   mem_addr        request byte address
//   mem_write_data  write-through data
//   mem_read_data   refilled line, word i at [32i+31:32i]
//   mem_ready       one-cycle completion pulse
//   mem_error       one-cycle pulse with mem_ready when a beat timed out
//   busy            controller not idle
//   ext_req/ext_we  external word request / write enable, held until ack
//   ext_addr        external word address (bits [1:0] = 0)
//   ext_wdata       external write data
//   ext_rdata       external read data, valid with ext_ack
//   ext_ack         beat complete
// -----------------------------------------------------------------------------
module mem_refill_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_req,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_write_data,
  output logic [LINE_W-1:0]   mem_read_data,
  output logic                mem_ready,
  output logic                mem_error,
  output logic                busy,
  output logic                ext_req,
  output logic                ext_we,
  output logic [ADDR_W-1:0]   ext_addr,
  output logic [WORD_W-1:0]   ext_wdata,
  input  logic [WORD_W-1:0]   ext_rdata,
  input  logic                ext_ack
);

  // The timeout fires on the edge that would complete the TIMEOUT_CYCLES-th
  // wait cycle, so the counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int          TCNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  refill_state_t state_q, state_d;

  logic [ADDR_W-1:2]                     addr_q;   // word address of the request
  logic [WORD_W-1:0]                     wdata_q;
  logic [1:0]                            beat_q;
  logic [TCNT_W-1:0]                     tcnt_q;
  logic                                  err_q;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_q, line_d;

  logic accept;
  logic last_beat;
  logic timeout_hit;

  // Byte offset within a word never reaches the external port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  assign accept      = (state_q == IDLE) && mem_req;
  assign last_beat   = (beat_q == 2'(WORDS_PER_LINE - 1));
  // An ack on the same edge wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ext_req && !ext_ack &&
                       (tcnt_q == TCNT_W'(TO_LAST));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (mem_req) state_d = mem_write ? WR_WORD : RD_BURST;
      RD_BURST: if ((ext_ack && last_beat) || timeout_hit) state_d = RESP;
      WR_WORD:  if (ext_ack || timeout_hit) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Line buffer with the current beat's word merged in, so the final beat
  // can be copied to mem_read_data on the same edge it arrives.
  always_comb begin
    line_d = line_q;
    if (state_q == RD_BURST && ext_ack) line_d[beat_q] = ext_rdata;
  end

  // ---------------------------------------------------------------------------
  // Datapath: request capture, beat / timeout counters, line assembly
  // ---------------------------------------------------------------------------
  // NOTE: the line buffer is only four words, so it is reset along with the
  // rest; this also guarantees a reset discards any partially filled line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      beat_q        <= '0;
      tcnt_q        <= '0;
      err_q         <= 1'b0;
      line_q        <= '0;
      mem_read_data <= '0;
    end else begin
      line_q <= line_d;
      if (accept) begin
        addr_q  <= mem_addr[ADDR_W-1:2];
        wdata_q <= mem_write_data;
        beat_q  <= '0;
        tcnt_q  <= '0;
        err_q   <= 1'b0;
      end else if (ext_req) begin
        if (ext_ack) begin
          tcnt_q <= '0;
          if (state_q == RD_BURST) begin
            beat_q <= beat_q + 2'd1;
            if (last_beat) mem_read_data <= line_d;
          end
        end else if (timeout_hit) begin
          tcnt_q <= '0;
          err_q  <= 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from state so ext_req falls as soon as reset asserts)
  // ---------------------------------------------------------------------------
  always_comb begin
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      RD_BURST: begin
        ext_req  = 1'b1;
        ext_addr = {addr_q[ADDR_W-1:4], beat_q, 2'b00};
      end
      WR_WORD: begin
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = {addr_q, 2'b00};
        ext_wdata = wdata_q;
      end
      RESP: begin
        mem_ready = 1'b1;
        mem_error = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_refill_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_refill_controller
//   Directed scenarios plus randomized transactions against a transaction-level
//   model: the bench plays the external memory, and for every request predicts
//   the word addresses, completion latency (sum of beat costs, or the timeout
//   budget), the error flag and the resulting line.
// -----------------------------------------------------------------------------
module tb_mem_refill_controller;
  import cache_pkg::*;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [127:0] mem_read_data;
  logic         mem_ready;
  logic         mem_error;
  logic         busy;
  logic         ext_req;
  logic         ext_we;
  logic [31:0]  ext_addr;
  logic [31:0]  ext_wdata;
  logic [31:0]  ext_rdata;
  logic         ext_ack;

  mem_refill_controller #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
    .mem_error      (mem_error),
    .busy           (busy),
    .ext_req        (ext_req),
    .ext_we         (ext_we),
    .ext_addr       (ext_addr),
    .ext_wdata      (ext_wdata),
    .ext_rdata      (ext_rdata),
    .ext_ack        (ext_ack)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] exp_line;                 // model of mem_read_data
  logic [31:0]  mem_img [logic [31:0]];   // explicit memory contents

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Present a request at a negedge; returns just after the accepting edge.
  task automatic start_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input bit keep);
    @(negedge clk);
    check("idle_before_req", busy, 1'b0);
    mem_req        = 1'b1;
    mem_write      = wr;
    mem_addr       = addr;
    mem_write_data = wd;
    @(posedge clk);
    #1;
    if (!keep) begin
      mem_req        = 1'b0;
      mem_write      = 1'($urandom);
      mem_addr       = $urandom;
      mem_write_data = $urandom;
    end
  endtask

  // Act as the external memory for one accepted request. waits[b] is the
  // number of cycles ext_req is left unacknowledged on beat b; a value of TO
  // or more means the beat is never acknowledged. stop_beat >= 0 returns as
  // soon as that many beats have completed (for the reset-abort scenario).
  task automatic run_resp(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits[4], input int stop_beat, input bit noise,
                          input bit check_idle);
    int           nbeats, beat, wc, edges, exp_c, got_c;
    bit           err, seen;
    logic [127:0] line;
    logic [31:0]  ea;

    // Expected outcome from the beat costs alone.
    nbeats = wr ? 1 : 4;
    err    = 1'b0;
    edges  = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (waits[b] >= TO) begin
        edges += TO;
        err    = 1'b1;
        break;
      end
      edges += waits[b] + 1;
    end
    exp_c = edges + 1;

    line  = exp_line;
    beat  = 0;
    wc    = 0;
    seen  = 1'b0;
    got_c = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_after_accept", busy, 1'b1);
      if (mem_ready) begin
        seen    = 1'b1;
        got_c   = c;
        ext_ack = 1'b0;
        if (noise) mem_req = 1'b0;
      end else if (stop_beat >= 0 && beat == stop_beat) begin
        ext_ack = 1'b0;
        return;
      end else begin
        if (noise) begin
          mem_req   = 1'($urandom);
          mem_write = 1'($urandom);
          mem_addr  = $urandom;
        end
        ea = wr ? {addr[31:2], 2'b00} : line_base(addr) + 32'(4 * beat);
        if (ext_req && wc == 0) begin
          check("ext_addr", ext_addr, ea);
          check("ext_we", ext_we, wr);
          if (wr) check("ext_wdata", ext_wdata, wd);
        end
        if (ext_req && beat < nbeats && wc == waits[beat]) begin
          ext_ack   = 1'b1;
          ext_rdata = word_at(ea);
          if (!wr) line[32*beat +: 32] = ext_rdata;
          beat++;
          wc = 0;
        end else begin
          ext_ack   = 1'b0;
          ext_rdata = $urandom;
          wc++;
        end
      end
    end

    check("ready_seen", seen, 1'b1);
    check("ready_latency", got_c, exp_c);
    check("mem_error", mem_error, err);
    check("ext_req_in_resp", ext_req, 1'b0);
    if (!wr && !err) exp_line = line;
    check("mem_read_data", mem_read_data, exp_line);

    if (check_idle) begin
      @(negedge clk);
      check("ready_one_cycle", mem_ready, 1'b0);
      check("error_one_cycle", mem_error, 1'b0);
      check("idle_after_resp", busy, 1'b0);
      check("ext_req_idle", ext_req, 1'b0);
    end
  endtask

  int          w[4];
  bit          rwr;
  logic [31:0] raddr, rwd;

  initial begin
    reset          = 1'b1;
    mem_req        = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    ext_rdata      = '0;
    ext_ack        = 1'b0;
    exp_line       = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ext_req", ext_req, 1'b0);
    check("rst_ext_we", ext_we, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_mem_error", mem_error, 1'b0);
    check("rst_ext_addr", ext_addr, 32'h0);
    check("rst_ext_wdata", ext_wdata, 32'h0);
    check("rst_read_data", mem_read_data, 128'h0);
    reset = 1'b0;

    // Zero-wait refill of line 0x50 with known contents.
    mem_img[32'h50] = 32'h90AB_CDEF;
    mem_img[32'h54] = 32'h1234_5678;
    mem_img[32'h58] = 32'hCAFE_BABE;
    mem_img[32'h5C] = 32'hDEAD_BEEF;
    w = '{0, 0, 0, 0};
    start_req(1'b0, 32'h0000_0050, 32'h0, 1'b0);
    run_resp(1'b0, 32'h0000_0050, 32'h0, w, -1, 1'b0, 1'b1);
    check("known_line", mem_read_data, 128'hDEADBEEF_CAFEBABE_12345678_90ABCDEF);

    // Reset after two beats of a burst: transfer dropped, line cleared.
    start_req(1'b0, 32'h0000_0200, 32'h0, 1'b0);
    run_resp(1'b0, 32'h0000_0200, 32'h0, w, 2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rstmid_ext_req", ext_req, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ready", mem_ready, 1'b0);
    check("rstmid_line", mem_read_data, 128'h0);
    exp_line = '0;
    @(negedge clk);
    check("rstmid_no_ready", mem_ready, 1'b0);
    reset = 1'b0;
    start_req(1'b0, 32'h0000_0300, 32'h0, 1'b0);
    run_resp(1'b0, 32'h0000_0300, 32'h0, w, -1, 1'b0, 1'b1);

    // Unaligned read, three wait cycles on every beat.
    w = '{3, 3, 3, 3};
    start_req(1'b0, 32'h0000_0157, 32'h0, 1'b0);
    run_resp(1'b0, 32'h0000_0157, 32'h0, w, -1, 1'b0, 1'b1);

    // Write-through, line must be untouched.
    w = '{0, 0, 0, 0};
    start_req(1'b1, 32'h0000_00A2, 32'hCCCC_DDDD, 1'b0);
    run_resp(1'b1, 32'h0000_00A2, 32'hCCCC_DDDD, w, -1, 1'b0, 1'b1);

    // Hung memory on beat 1.
    w = '{0, 100, 0, 0};
    start_req(1'b0, 32'h0000_0400, 32'h0, 1'b0);
    run_resp(1'b0, 32'h0000_0400, 32'h0, w, -1, 1'b0, 1'b1);

    // mem_req held high through RESP: one idle cycle, then re-accept.
    w = '{0, 0, 0, 0};
    start_req(1'b1, 32'h0000_0060, 32'h1111_2222, 1'b1);
    run_resp(1'b1, 32'h0000_0060, 32'h1111_2222, w, -1, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_idle_busy", busy, 1'b0);
    check("hold_idle_ready", mem_ready, 1'b0);
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    run_resp(1'b1, 32'h0000_0060, 32'h1111_2222, w, -1, 1'b0, 1'b1);

    // Randomized traffic, including wait counts either side of the timeout.
    for (int t = 0; t < 40; t++) begin
      rwr   = 1'($urandom);
      raddr = $urandom;
      rwd   = $urandom;
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 9))
          0:       w[b] = TO - 1;
          1:       w[b] = TO;
          default: w[b] = int'($urandom_range(0, 3));
        endcase
      end
      start_req(rwr, raddr, rwd, 1'b0);
      run_resp(rwr, raddr, rwd, w, -1, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 1_000_000);
    $fatal(1);
  end

endmodule
